// File: rtl/datapath_bus_arb.sv
// Registered shared-bus arbiter: selects one of NSRC gated sources onto a
// WIDTH-bit bus with fixed-priority or round-robin grant, and flags/counts
// cycles where more than one gate is asserted.
module datapath_bus_arb #(
    parameter int WIDTH     = 16,
    parameter int NSRC      = 4,
    parameter int MODE      = 0,
    parameter int IDLE_HOLD = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NSRC-1:0]         gate,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_valid,
    output logic [$clog2(NSRC)-1:0] bus_src,
    output logic                    conflict,
    output logic [7:0]              conflict_count
);

    localparam int SW = $clog2(NSRC);

    logic [WIDTH-1:0] r_bus_out;
    logic             r_bus_valid;
    logic [SW-1:0]    r_bus_src;
    logic             r_conflict;
    logic [7:0]       r_conflict_count;
    logic [SW-1:0]    r_rr_last;

    logic             w_any;
    logic [SW-1:0]    w_grant_idx;
    logic [4:0]       w_popcnt;
    logic             w_multi;
    logic [WIDTH-1:0] w_sel_data;

    // Grant selection on the sampled gate vector
    always_comb begin
        logic [NSRC-1:0] w_shifted;
        int              j;
        logic            w_found;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_shifted   = '0;
        j           = 0;
        if (MODE == 0) begin
            // Scan downward so the lowest asserted index is the last writer
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (gate[i]) begin
                    w_grant_idx = SW'(i);
                end
            end
        end else begin
            // Scan upward from rr_last+1; wrap stays below NSRC for any NSRC
            for (int k = 1; k <= NSRC; k++) begin
                j = int'(r_rr_last) + k;
                if (j >= NSRC) begin
                    j = j - NSRC;
                end
                w_shifted = gate >> j;
                if (!w_found && w_shifted[0]) begin
                    w_grant_idx = SW'(j);
                    w_found     = 1'b1;
                end
            end
        end
    end

    // Gate population count for conflict detection, plus granted data select
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_popcnt = w_popcnt + 5'(gate[i]);
        end
        w_any      = |gate;
        w_multi    = (w_popcnt >= 5'd2);
        w_sel_data = src_data[int'(w_grant_idx)*WIDTH +: WIDTH];
    end

    // Bus output, grant bookkeeping and round-robin pointer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
            r_bus_src   <= '0;
            r_rr_last   <= SW'(NSRC - 1);
        end else if (w_any) begin
            r_bus_out   <= w_sel_data;
            r_bus_valid <= 1'b1;
            r_bus_src   <= w_grant_idx;
            r_rr_last   <= w_grant_idx;
        end else begin
            r_bus_valid <= 1'b0;
            if (IDLE_HOLD == 0) begin
                r_bus_out <= '0;
            end
        end
    end

    // Conflict flag and saturating conflict counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_conflict       <= 1'b0;
            r_conflict_count <= '0;
        end else begin
            r_conflict <= w_multi;
            if (w_multi && (r_conflict_count != 8'hFF)) begin
                r_conflict_count <= r_conflict_count + 8'd1;
            end
        end
    end

    assign bus_out        = r_bus_out;
    assign bus_valid      = r_bus_valid;
    assign bus_src        = r_bus_src;
    assign conflict       = r_conflict;
    assign conflict_count = r_conflict_count;

endmodule

// File: tb/tb_datapath_bus_arb.sv
// Directed bench for datapath_bus_arb: fixed-priority, round-robin (NSRC=4
// and NSRC=3), and idle-hold variants driven from a shared stimulus.
module tb_datapath_bus_arb;

    logic        Clk;
    logic        Reset;
    logic [3:0]  gate;
    logic [63:0] src_data;

    logic [15:0] fp_out,  rr_out,  hd_out,  r3_out;
    logic        fp_vld,  rr_vld,  hd_vld,  r3_vld;
    logic [1:0]  fp_src,  rr_src,  hd_src,  r3_src;
    logic        fp_cf,   rr_cf,   hd_cf,   r3_cf;
    logic [7:0]  fp_cnt,  rr_cnt,  hd_cnt,  r3_cnt;

    int n_checks;
    int n_fail;

    datapath_bus_arb #(.WIDTH(16), .NSRC(4), .MODE(0), .IDLE_HOLD(0)) u_fp (
        .Clk(Clk), .Reset(Reset), .gate(gate), .src_data(src_data),
        .bus_out(fp_out), .bus_valid(fp_vld), .bus_src(fp_src),
        .conflict(fp_cf), .conflict_count(fp_cnt)
    );

    datapath_bus_arb #(.WIDTH(16), .NSRC(4), .MODE(1), .IDLE_HOLD(0)) u_rr (
        .Clk(Clk), .Reset(Reset), .gate(gate), .src_data(src_data),
        .bus_out(rr_out), .bus_valid(rr_vld), .bus_src(rr_src),
        .conflict(rr_cf), .conflict_count(rr_cnt)
    );

    datapath_bus_arb #(.WIDTH(16), .NSRC(4), .MODE(0), .IDLE_HOLD(1)) u_hold (
        .Clk(Clk), .Reset(Reset), .gate(gate), .src_data(src_data),
        .bus_out(hd_out), .bus_valid(hd_vld), .bus_src(hd_src),
        .conflict(hd_cf), .conflict_count(hd_cnt)
    );

    datapath_bus_arb #(.WIDTH(16), .NSRC(3), .MODE(1), .IDLE_HOLD(0)) u_rr3 (
        .Clk(Clk), .Reset(Reset), .gate(gate[2:0]), .src_data(src_data[47:0]),
        .bus_out(r3_out), .bus_valid(r3_vld), .bus_src(r3_src),
        .conflict(r3_cf), .conflict_count(r3_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_src(input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] s2, input logic [15:0] s3);
        src_data = {s3, s2, s1, s0};
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    logic [1:0] rr_seq [5];
    logic [1:0] r3_seq [5];
    logic [1:0] sp_seq [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b1;
        gate     = 4'b0000;
        set_src(16'h0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        check("rst_fp_out", 32'(fp_out), 32'h0);
        check("rst_fp_vld", 32'(fp_vld), 32'h0);
        check("rst_fp_src", 32'(fp_src), 32'h0);
        check("rst_fp_cf",  32'(fp_cf),  32'h0);
        check("rst_fp_cnt", 32'(fp_cnt), 32'h0);
        Reset = 1'b0;

        // Fixed priority single grant, then idle
        gate = 4'b0100;
        set_src(16'h0, 16'h0, 16'hBEEF, 16'h0);
        step();
        check("fp1_out", 32'(fp_out), 32'hBEEF);
        check("fp1_vld", 32'(fp_vld), 32'h1);
        check("fp1_src", 32'(fp_src), 32'h2);
        check("fp1_cf",  32'(fp_cf),  32'h0);
        gate = 4'b0000;
        step();
        check("fp_idle_out", 32'(fp_out), 32'h0);
        check("fp_idle_vld", 32'(fp_vld), 32'h0);
        check("fp_idle_src", 32'(fp_src), 32'h2);
        check("hd_idle_out", 32'(hd_out), 32'hBEEF);

        // Fixed priority conflict: lowest index wins, no data merging
        gate = 4'b1010;
        set_src(16'h0, 16'h1111, 16'h0, 16'h3333);
        step();
        check("fpc_out", 32'(fp_out), 32'h1111);
        check("fpc_src", 32'(fp_src), 32'h1);
        check("fpc_cf",  32'(fp_cf),  32'h1);
        check("fpc_cnt1", 32'(fp_cnt), 32'h1);
        step();
        step();
        check("fpc_cnt3", 32'(fp_cnt), 32'h3);
        gate = 4'b0000;
        step();
        check("fpc_cf_clr", 32'(fp_cf), 32'h0);
        check("fpc_cnt_hold", 32'(fp_cnt), 32'h3);

        // Reset with gates asserted overrides the grant
        Reset = 1'b1;
        gate  = 4'b0011;
        step();
        check("rst2_fp_out", 32'(fp_out), 32'h0);
        check("rst2_fp_vld", 32'(fp_vld), 32'h0);
        check("rst2_rr_src", 32'(rr_src), 32'h0);
        check("rst2_fp_cf",  32'(fp_cf),  32'h0);
        check("rst2_fp_cnt", 32'(fp_cnt), 32'h0);
        Reset = 1'b0;

        // Round-robin rotation with all gates held
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        r3_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        gate = 4'b1111;
        set_src(16'hA000, 16'hA111, 16'hA222, 16'hA333);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rr_src%0d", i), 32'(rr_src), 32'(rr_seq[i]));
            check($sformatf("r3_src%0d", i), 32'(r3_src), 32'(r3_seq[i]));
        end
        check("rr_out_last", 32'(rr_out), 32'hA000);
        check("fp_rr_src",   32'(fp_src), 32'h0);
        check("rr_cnt5",     32'(rr_cnt), 32'h5);

        // Idle cycle must not move the round-robin pointer
        gate = 4'b0000;
        step();
        gate = 4'b1111;
        step();
        check("rr_after_idle", 32'(rr_src), 32'h1);

        // Sparse round-robin; NSRC=3 instance sees only gate0 and re-grants it
        do_reset();
        sp_seq = '{2'd0, 2'd3, 2'd0, 2'd3};
        gate = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("sp_src%0d", i), 32'(rr_src), 32'(sp_seq[i]));
            check($sformatf("sp3_src%0d", i), 32'(r3_src), 32'h0);
        end
        check("sp_out", 32'(rr_out), 32'hA333);

        // Idle hold variant
        do_reset();
        gate = 4'b0001;
        set_src(16'hABCD, 16'h0, 16'h0, 16'h0);
        step();
        check("hd_grant", 32'(hd_out), 32'hABCD);
        gate = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hd_out%0d", i), 32'(hd_out), 32'hABCD);
            check($sformatf("hd_vld%0d", i), 32'(hd_vld), 32'h0);
            check($sformatf("hd_src%0d", i), 32'(hd_src), 32'h0);
        end
        check("fp_no_hold", 32'(fp_out), 32'h0);

        // Data changing under a held gate follows with one cycle latency
        gate = 4'b0001;
        set_src(16'h1234, 16'h0, 16'h0, 16'h0);
        step();
        set_src(16'h5678, 16'h0, 16'h0, 16'h0);
        check("dchg_a", 32'(fp_out), 32'h1234);
        step();
        check("dchg_b", 32'(fp_out), 32'h5678);

        // Counter saturation
        do_reset();
        gate = 4'b0011;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        check("sat_cnt", 32'(fp_cnt), 32'hFF);
        check("sat_cf",  32'(fp_cf),  32'h1);

        // Reset with gates asserted, then first grant after release
        Reset = 1'b1;
        step();
        check("rst3_fp_out", 32'(fp_out), 32'h0);
        check("rst3_fp_vld", 32'(fp_vld), 32'h0);
        check("rst3_rr_src", 32'(rr_src), 32'h0);
        check("rst3_fp_cf",  32'(fp_cf),  32'h0);
        check("rst3_fp_cnt", 32'(fp_cnt), 32'h0);
        Reset = 1'b0;
        gate  = 4'b1111;
        step();
        check("post_rst_rr_src", 32'(rr_src), 32'h0);
        check("post_rst_rr_vld", 32'(rr_vld), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
